// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pkg
// Brief   : Shared widths, FSM state encoding and ex->mem control struct
// Revision: 1.0
// ============================================================================
package mem_stage_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int WADDR_W   = 30;

    typedef enum logic [0:0] {
        MS_IDLE   = 1'b0,
        MS_ACCESS = 1'b1
    } ms_state_t;

    typedef struct packed {
        logic                 mem_rd;
        logic                 mem_wr;
        logic                 reg_wr;
        logic [REG_IDX_W-1:0] rd;
    } ex_ctrl_t;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_stage
// Brief   : Memory stage: word load/store over req/ack port, one wb result
//           per instruction. Optional MEM_ALIGN_CHECK_EN flags misaligned ops.
// Revision: 1.0
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = mem_stage_pkg::DATA_W,
    parameter int REG_IDX_W = mem_stage_pkg::REG_IDX_W,
    parameter int WADDR_W   = mem_stage_pkg::WADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [DATA_W-1:0]    ex_alu_res,
    input  logic [DATA_W-1:0]    ex_store_data,
    input  logic                 ex_mem_rd,
    input  logic                 ex_mem_wr,
    input  logic                 ex_reg_wr,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [WADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]    dm_wdata,
    input  logic                 dm_ack,
    input  logic [DATA_W-1:0]    dm_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_wr,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data
`ifdef MEM_ALIGN_CHECK_EN
    ,output logic                misalign_err
`endif
);

    ms_state_t              r_state;
    ms_state_t              w_state_next;
    logic                   r_dm_req;
    logic                   r_dm_we;
    logic [WADDR_W-1:0]     r_dm_addr;
    logic [DATA_W-1:0]      r_dm_wdata;
    logic [REG_IDX_W-1:0]   r_rd;
    logic                   r_reg_wr;
    logic                   r_wb_valid;
    logic                   r_wb_reg_wr;
    logic [REG_IDX_W-1:0]   r_wb_rd;
    logic [DATA_W-1:0]      r_wb_data;
    logic                   r_misalign;

    ex_ctrl_t               w_ctrl;
    logic                   w_xfer;
    logic                   w_is_mem;
    logic                   w_misalign;
    logic                   w_rd_nz;

    assign w_ctrl   = '{mem_rd: ex_mem_rd, mem_wr: ex_mem_wr, reg_wr: ex_reg_wr, rd: ex_rd};
    assign ex_ready = (r_state == MS_IDLE) && !rst;
    assign w_xfer   = ex_valid && ex_ready;
    assign w_is_mem = w_ctrl.mem_rd || w_ctrl.mem_wr;
    assign w_rd_nz  = (w_ctrl.rd != '0);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (ex_alu_res[1:0] != 2'b00);
`else
    logic w_unused_lsb;
    assign w_misalign   = 1'b0;
    assign w_unused_lsb = ^ex_alu_res[1:0];
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MS_IDLE:   if (w_xfer && w_is_mem && !w_misalign) w_state_next = MS_ACCESS;
            MS_ACCESS: if (dm_ack) w_state_next = MS_IDLE;
            default:   w_state_next = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MS_IDLE;
            r_dm_req    <= 1'b0;
            r_dm_we     <= 1'b0;
            r_dm_addr   <= '0;
            r_dm_wdata  <= '0;
            r_rd        <= '0;
            r_reg_wr    <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_reg_wr <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wb_valid <= 1'b0;
            r_misalign <= 1'b0;
            if (r_state == MS_IDLE) begin
                if (w_xfer && w_is_mem && w_misalign) begin
                    r_wb_valid  <= 1'b1;
                    r_wb_reg_wr <= 1'b0;
                    r_wb_rd     <= w_ctrl.rd;
                    r_wb_data   <= '0;
                    r_misalign  <= 1'b1;
                end else if (w_xfer && w_is_mem) begin
                    // A store wins when both mem_rd and mem_wr are set.
                    r_dm_req   <= 1'b1;
                    r_dm_we    <= w_ctrl.mem_wr;
                    r_dm_addr  <= ex_alu_res[WADDR_W+1:2];
                    r_dm_wdata <= ex_store_data;
                    r_rd       <= w_ctrl.rd;
                    r_reg_wr   <= w_ctrl.reg_wr && !w_ctrl.mem_wr && w_rd_nz;
                end else if (w_xfer) begin
                    r_wb_valid  <= 1'b1;
                    r_wb_reg_wr <= w_ctrl.reg_wr && w_rd_nz;
                    r_wb_rd     <= w_ctrl.rd;
                    r_wb_data   <= ex_alu_res;
                end
            end else if (dm_ack) begin
                r_dm_req    <= 1'b0;
                r_wb_valid  <= 1'b1;
                r_wb_rd     <= r_rd;
                r_wb_reg_wr <= r_dm_we ? 1'b0 : r_reg_wr;
                r_wb_data   <= r_dm_we ? '0 : dm_rdata;
            end
        end
    end

    assign dm_req    = r_dm_req;
    assign dm_we     = r_dm_we;
    assign dm_addr   = r_dm_addr;
    assign dm_wdata  = r_dm_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_reg_wr = r_wb_reg_wr;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_err = r_misalign;
`else
    logic w_unused_misalign;
    assign w_unused_misalign = r_misalign;
`endif

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_stage
// Brief   : Directed self-checking bench for mem_access_stage
// Revision: 1.0
// ============================================================================
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ex_valid;
    logic                 ex_ready;
    logic [DATA_W-1:0]    ex_alu_res;
    logic [DATA_W-1:0]    ex_store_data;
    logic                 ex_mem_rd;
    logic                 ex_mem_wr;
    logic                 ex_reg_wr;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 dm_req;
    logic                 dm_we;
    logic [WADDR_W-1:0]   dm_addr;
    logic [DATA_W-1:0]    dm_wdata;
    logic                 dm_ack;
    logic [DATA_W-1:0]    dm_rdata;
    logic                 wb_valid;
    logic                 wb_reg_wr;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [DATA_W-1:0]    wb_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic                 misalign_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_res    (ex_alu_res),
        .ex_store_data (ex_store_data),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_reg_wr     (ex_reg_wr),
        .ex_rd         (ex_rd),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_ack        (dm_ack),
        .dm_rdata      (dm_rdata),
        .wb_valid      (wb_valid),
        .wb_reg_wr     (wb_reg_wr),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data)
`ifdef MEM_ALIGN_CHECK_EN
        ,.misalign_err (misalign_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] res, input logic [31:0] sd,
                            input logic rd_op, input logic wr_op,
                            input logic rw, input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_alu_res    = res;
        ex_store_data = sd;
        ex_mem_rd     = rd_op;
        ex_mem_wr     = wr_op;
        ex_reg_wr     = rw;
        ex_rd         = rd;
    endtask

    task automatic idle_in();
        ex_valid  = 1'b0;
        ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
        ex_reg_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        ex_alu_res = '0; ex_store_data = '0; ex_rd = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        tick(); tick();
        n_vec++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL rst_ex_ready got %0h exp 0", ex_ready); end
        n_vec++; if ({dm_req, dm_we, dm_addr, dm_wdata} !== '0) begin n_err++; $display("FAIL rst_dm got %0h/%0h/%0h/%0h exp 0", dm_req, dm_we, dm_addr, dm_wdata); end
        n_vec++; if ({wb_valid, wb_reg_wr, wb_rd, wb_data} !== '0) begin n_err++; $display("FAIL rst_wb got %0h/%0h/%0h/%0h exp 0", wb_valid, wb_reg_wr, wb_rd, wb_data); end
        rst = 1'b0;
        #1;
        n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %0h exp 1", ex_ready); end
    endtask

    task automatic test_alu();
        drive_op(32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5);
        tick();
        idle_in();
        n_vec++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL alu_wb_valid got %0h exp 1", wb_valid); end
        n_vec++; if (wb_data !== 32'h10) begin n_err++; $display("FAIL alu_wb_data got %0h exp 10", wb_data); end
        n_vec++; if (wb_rd !== 5'd5 || wb_reg_wr !== 1'b1) begin n_err++; $display("FAIL alu_wb_rd got rd=%0d we=%0h exp rd=5 we=1", wb_rd, wb_reg_wr); end
        n_vec++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL alu_dm_req got %0h exp 0", dm_req); end
        tick();
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL alu_pulse got %0h exp 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        drive_op(32'hAAAA_0001, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1);
        tick();
        drive_op(32'hBBBB_0002, 32'h0, 1'b0, 1'b0, 1'b1, 5'd2);
        n_vec++; if (wb_valid !== 1'b1 || wb_data !== 32'hAAAA_0001 || wb_rd !== 5'd1) begin n_err++; $display("FAIL b2b_first got v=%0h d=%0h rd=%0d exp v=1 d=aaaa0001 rd=1", wb_valid, wb_data, wb_rd); end
        n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %0h exp 1", ex_ready); end
        tick();
        idle_in();
        n_vec++; if (wb_valid !== 1'b1 || wb_data !== 32'hBBBB_0002 || wb_rd !== 5'd2) begin n_err++; $display("FAIL b2b_second got v=%0h d=%0h rd=%0d exp v=1 d=bbbb0002 rd=2", wb_valid, wb_data, wb_rd); end
        tick();
    endtask

    task automatic test_load();
        drive_op(32'h0000_0104, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7);
        tick();
        // Offer an ALU op while stalled; it must be ignored.
        drive_op(32'h5555_5555, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9);
        n_vec++; if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 30'h41) begin n_err++; $display("FAIL lw_req got req=%0h we=%0h addr=%0h exp 1/0/41", dm_req, dm_we, dm_addr); end
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL lw_stall_ready got %0h exp 0", ex_ready); end
            tick();
            n_vec++; if (dm_req !== 1'b1 || dm_addr !== 30'h41 || wb_valid !== 1'b0) begin n_err++; $display("FAIL lw_hold got req=%0h addr=%0h v=%0h exp 1/41/0", dm_req, dm_addr, wb_valid); end
        end
        idle_in();
        dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        tick();
        dm_ack = 1'b0;
        n_vec++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_data got v=%0h d=%0h exp 1/deadbeef", wb_valid, wb_data); end
        n_vec++; if (wb_reg_wr !== 1'b1 || wb_rd !== 5'd7 || dm_req !== 1'b0 || ex_ready !== 1'b1) begin n_err++; $display("FAIL lw_done got we=%0h rd=%0d req=%0h rdy=%0h exp 1/7/0/1", wb_reg_wr, wb_rd, dm_req, ex_ready); end
        tick();
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL lw_pulse got %0h exp 0", wb_valid); end
    endtask

    task automatic test_store();
        drive_op(32'h0000_0020, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd9);
        tick();
        idle_in();
        n_vec++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_addr !== 30'h8 || dm_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL sw_req got req=%0h we=%0h a=%0h d=%0h exp 1/1/8/12345678", dm_req, dm_we, dm_addr, dm_wdata); end
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        n_vec++; if (wb_valid !== 1'b1 || wb_reg_wr !== 1'b0 || wb_data !== 32'h0) begin n_err++; $display("FAIL sw_wb got v=%0h we=%0h d=%0h exp 1/0/0", wb_valid, wb_reg_wr, wb_data); end
        n_vec++; if (ex_ready !== 1'b1 || dm_req !== 1'b0) begin n_err++; $display("FAIL sw_ready got rdy=%0h req=%0h exp 1/0", ex_ready, dm_req); end
        // Both mem_rd and mem_wr: executed as a store.
        drive_op(32'h0000_0040, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 5'd3);
        tick();
        idle_in();
        n_vec++; if (dm_we !== 1'b1 || dm_addr !== 30'h10) begin n_err++; $display("FAIL rdwr_we got we=%0h a=%0h exp 1/10", dm_we, dm_addr); end
        dm_ack = 1'b1; dm_rdata = 32'h9999_9999;
        tick();
        dm_ack = 1'b0;
        n_vec++; if (wb_valid !== 1'b1 || wb_reg_wr !== 1'b0 || wb_data !== 32'h0) begin n_err++; $display("FAIL rdwr_wb got v=%0h we=%0h d=%0h exp 1/0/0", wb_valid, wb_reg_wr, wb_data); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        drive_op(32'h0000_0200, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4);
        tick();
        idle_in();
        n_vec++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL rma_req got %0h exp 1", dm_req); end
        rst = 1'b1;
        #1;
        n_vec++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL rma_ready_comb got %0h exp 0", ex_ready); end
        tick();
        n_vec++; if (dm_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b0) begin n_err++; $display("FAIL rma_after got req=%0h v=%0h rdy=%0h exp 0/0/0", dm_req, wb_valid, ex_ready); end
        rst = 1'b0;
        drive_op(32'h0000_0077, 32'h0, 1'b0, 1'b0, 1'b1, 5'd6);
        tick();
        idle_in();
        n_vec++; if (wb_valid !== 1'b1 || wb_data !== 32'h77 || wb_rd !== 5'd6) begin n_err++; $display("FAIL rma_add got v=%0h d=%0h rd=%0d exp 1/77/6", wb_valid, wb_data, wb_rd); end
        tick();
    endtask

    task automatic test_rd_zero_and_spurious_ack();
        drive_op(32'h0000_0300, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0);
        tick();
        idle_in();
        dm_ack = 1'b1; dm_rdata = 32'hCAFE_0000;
        tick();
        dm_ack = 1'b0;
        n_vec++; if (wb_valid !== 1'b1 || wb_reg_wr !== 1'b0 || wb_data !== 32'hCAFE_0000) begin n_err++; $display("FAIL rd0_wb got v=%0h we=%0h d=%0h exp 1/0/cafe0000", wb_valid, wb_reg_wr, wb_data); end
        tick();
        // ALU op with rd=0 also must not write.
        drive_op(32'h0000_0042, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0);
        tick();
        idle_in();
        n_vec++; if (wb_valid !== 1'b1 || wb_reg_wr !== 1'b0) begin n_err++; $display("FAIL rd0_alu got v=%0h we=%0h exp 1/0", wb_valid, wb_reg_wr); end
        dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
        tick();
        tick();
        dm_ack = 1'b0;
        n_vec++; if (wb_valid !== 1'b0 || dm_req !== 1'b0 || wb_data !== 32'h42 || ex_ready !== 1'b1) begin n_err++; $display("FAIL spurious_ack got v=%0h req=%0h d=%0h rdy=%0h exp 0/0/42/1", wb_valid, dm_req, wb_data, ex_ready); end
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_misalign();
        drive_op(32'h0000_0102, 32'h0, 1'b1, 1'b0, 1'b1, 5'd8);
        tick();
        idle_in();
        n_vec++; if (dm_req !== 1'b0 || wb_valid !== 1'b1 || wb_reg_wr !== 1'b0 || misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign got req=%0h v=%0h we=%0h err=%0h exp 0/1/0/1", dm_req, wb_valid, wb_reg_wr, misalign_err); end
        n_vec++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL misalign_ready got %0h exp 1", ex_ready); end
        tick();
        n_vec++; if (misalign_err !== 1'b0 || wb_valid !== 1'b0 || dm_req !== 1'b0) begin n_err++; $display("FAIL misalign_pulse got err=%0h v=%0h req=%0h exp 0/0/0", misalign_err, wb_valid, dm_req); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_reset_mid_access();
        test_rd_zero_and_spurious_ack();
`ifdef MEM_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_access_stage
`default_nettype wire
